seq_detector_sr: RTL and testbench

Serial-in/parallel-out shift register with a Moore sequence detector for the pattern 1011 and a saturating match counter. It sits directly downstream of the D flip-flop stage with preset/clear and consumes that stage's q output as its serial input `din`. It exposes the last WIDTH received bits in parallel, a fill indicator, a match flag and a match count.

---
 rtl/seq_detector_sr.sv | 85 ++++++++
 tb/tb_seq_detector_sr.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_sr.sv
// Serial-in/parallel-out shift register with a Moore 1011 detector and saturating match counter.
// Define SEQ_DETECTOR_OVERLAP_EN to enable overlapping detection; the default is non-overlapping.
module seq_detector_sr #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q_par,
   output logic             valid,
   output logic             match,
   output logic [CNT_W-1:0] count
);

   localparam int FILL_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_G1,
      S_G10,
      S_G101,
      S_HIT
   } state_t;

   state_t             state_q, state_d, state_nxt;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   count_q, count_d;

   // Transition function on din alone; applied only when en is high.
   always_comb begin
      state_nxt = S_IDLE;
      case (state_q)
         S_IDLE: state_nxt = din ? S_G1   : S_IDLE;
         S_G1:   state_nxt = din ? S_G1   : S_G10;
         S_G10:  state_nxt = din ? S_G101 : S_IDLE;
         S_G101: state_nxt = din ? S_HIT  : S_G10;
`ifdef SEQ_DETECTOR_OVERLAP_EN
         S_HIT:  state_nxt = din ? S_G1   : S_G10;
`else
         S_HIT:  state_nxt = din ? S_G1   : S_IDLE;
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      fill_d  = fill_q;
      count_d = count_q;
      if (en) begin
         state_d = state_nxt;
         shift_d = {shift_q[WIDTH-2:0], din};
         if (fill_q != FILL_W'(WIDTH)) begin
            fill_d = fill_q + 1'b1;
         end
         if ((state_nxt == S_HIT) && (count_q != '1)) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         fill_q  <= fill_d;
         count_q <= count_d;
      end
   end

   assign q_par = shift_q;
   assign valid = (fill_q == FILL_W'(WIDTH));
   assign match = (state_q == S_HIT);
   assign count = count_q;

endmodule

// File: tb/tb_seq_detector_sr.sv
// Self-checking bench for seq_detector_sr (WIDTH=8, CNT_W=2); follows SEQ_DETECTOR_OVERLAP_EN.
module tb_seq_detector_sr;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en  = 1'b0;
   logic             din = 1'b0;
   logic [WIDTH-1:0] q_par;
   logic             valid;
   logic             match;
   logic [CNT_W-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [WIDTH-1:0] m_q;
   int               m_fill;
   bit               m_win[$];
   bit               m_match;
   int               m_cnt;

   seq_detector_sr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .din   (din),
      .q_par (q_par),
      .valid (valid),
      .match (match),
      .count (count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_q     = '0;
      m_fill  = 0;
      m_win.delete();
      m_match = 1'b0;
      m_cnt   = 0;
   endtask

   // Pattern matching over the bits received since reset (or since the last consumed match).
   task automatic model_edge(input bit e, input bit d);
      bit hit;
      if (!e) return;
      m_q = {m_q[WIDTH-2:0], d};
      if (m_fill < WIDTH) m_fill++;
      m_win.push_back(d);
      if (m_win.size() > 4) void'(m_win.pop_front());
      hit = (m_win.size() == 4) && m_win[0] && !m_win[1] && m_win[2] && m_win[3];
`ifndef SEQ_DETECTOR_OVERLAP_EN
      if (hit) m_win.delete();
`endif
      m_match = hit;
      if (hit && m_cnt < CNT_MAX) m_cnt++;
   endtask

   task automatic apply(input bit e, input bit d);
      en  = e;
      din = d;
      @(posedge clk);
      #1;
      model_edge(e, d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      din = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (q_par !== 8'h00) begin n_fail++; $display("FAIL reset_q_par: got %h want 00", q_par); end
      n_checks++;
      if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_checks++;
      if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", match); end
      n_checks++;
      if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
   endtask

   task automatic test_detect();
      bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
`ifdef SEQ_DETECTOR_OVERLAP_EN
      bit exp_m[7] = '{0, 0, 0, 1, 0, 0, 1};
      int exp_c[7] = '{0, 0, 0, 1, 1, 1, 2};
`else
      bit exp_m[7] = '{0, 0, 0, 1, 0, 0, 0};
      int exp_c[7] = '{0, 0, 0, 1, 1, 1, 1};
`endif
      do_reset();
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, stream[i]);
         n_checks++;
         if (match !== exp_m[i]) begin
            n_fail++; $display("FAIL detect_match edge %0d: got %b want %b", i + 1, match, exp_m[i]);
         end
         n_checks++;
         if (count !== CNT_W'(exp_c[i])) begin
            n_fail++; $display("FAIL detect_count edge %0d: got %0d want %0d", i + 1, count, exp_c[i]);
         end
      end
   endtask

   task automatic test_fill();
      bit stream[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, stream[i]);
         n_checks++;
         if (valid !== (i == 7)) begin
            n_fail++; $display("FAIL fill_valid edge %0d: got %b want %b", i + 1, valid, (i == 7));
         end
      end
      n_checks++;
      if (q_par !== 8'hB6) begin n_fail++; $display("FAIL fill_q_par: got %h want b6", q_par); end
   endtask

   task automatic test_enable_hold();
      do_reset();
      apply(1'b1, 1'b1); apply(1'b1, 1'b0); apply(1'b1, 1'b1); apply(1'b1, 1'b1);
      n_checks++;
      if (match !== 1'b1) begin n_fail++; $display("FAIL hold_enter_hit: got %b want 1", match); end
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, i[0]);
         n_checks++;
         if (match !== 1'b1 || q_par !== 8'h0B || count !== 2'd1) begin
            n_fail++;
            $display("FAIL hold edge %0d: got match=%b q_par=%h count=%0d want 1 0b 1", i, match, q_par, count);
         end
      end
      apply(1'b1, 1'b0);
      n_checks++;
      if (match !== 1'b0 || q_par !== 8'h16) begin
         n_fail++; $display("FAIL hold_release: got match=%b q_par=%h want 0 16", match, q_par);
      end
   endtask

   task automatic test_saturation();
      int exp_c[5] = '{1, 2, 3, 3, 3};
      do_reset();
      for (int r = 0; r < 5; r++) begin
         apply(1'b1, 1'b1); apply(1'b1, 1'b0); apply(1'b1, 1'b1); apply(1'b1, 1'b1);
         n_checks++;
         if (count !== CNT_W'(exp_c[r]) || match !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation round %0d: got count=%0d match=%b want %0d 1", r, count, match, exp_c[r]);
         end
         apply(1'b1, 1'b0); apply(1'b1, 1'b0);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      apply(1'b1, 1'b1); apply(1'b1, 1'b0); apply(1'b1, 1'b1); apply(1'b1, 1'b1);
      // Mid-cycle assertion: outputs must clear well before the next rising edge.
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (q_par !== 8'h00 || valid !== 1'b0 || match !== 1'b0 || count !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset: got q_par=%h valid=%b match=%b count=%0d want 00 0 0 0",
                  q_par, valid, match, count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      // Partial progress 1,0,1 then reset: detection must restart from scratch.
      apply(1'b1, 1'b1); apply(1'b1, 1'b0); apply(1'b1, 1'b1);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
      apply(1'b1, 1'b1);
      n_checks++;
      if (match !== 1'b0 || q_par !== 8'h01) begin
         n_fail++; $display("FAIL async_restart: got match=%b q_par=%h want 0 01", match, q_par);
      end
   endtask

   task automatic test_random();
      bit e, d;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(3, 0) != 0);
         d = ($urandom_range(2, 0) != 0);
         apply(e, d);
         n_checks++;
         if (q_par !== m_q) begin
            n_fail++; $display("FAIL rand_q_par step %0d: got %h want %h", i, q_par, m_q);
         end
         n_checks++;
         if (valid !== (m_fill == WIDTH)) begin
            n_fail++; $display("FAIL rand_valid step %0d: got %b want %b", i, valid, (m_fill == WIDTH));
         end
         n_checks++;
         if (match !== m_match) begin
            n_fail++; $display("FAIL rand_match step %0d: got %b want %b", i, match, m_match);
         end
         n_checks++;
         if (count !== CNT_W'(m_cnt)) begin
            n_fail++; $display("FAIL rand_count step %0d: got %0d want %0d", i, count, m_cnt);
         end
         if (i == 200) begin
            do_reset();
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_detect();
      test_fill();
      test_enable_hold();
      test_saturation();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
